// File: rtl/pea_scheduler_if.sv
// Handshake bundle between the PEA scheduler and its environment
// (enable module, invoke module, result/status output FIFOs).
interface pea_scheduler_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             halt;
  logic             enable;
  logic             fc;
  logic [1:0]       actor_next_mode;
  logic [CNT_W-1:0] result_count;
  logic [CNT_W-1:0] status_count;
  logic [1:0]       next_mode;
  logic             invoke;
  logic             rd_en_result;
  logic             rd_en_status;
  logic             busy;
  logic             error;
  logic [15:0]      firing_count;

  // Scheduler side
  modport master (
    input  start, halt, enable, fc, actor_next_mode, result_count, status_count,
    output next_mode, invoke, rd_en_result, rd_en_status, busy, error, firing_count
  );

  // Environment side (actor, FIFOs, control)
  modport slave (
    output start, halt, enable, fc, actor_next_mode, result_count, status_count,
    input  next_mode, invoke, rd_en_result, rd_en_status, busy, error, firing_count
  );
endinterface

// File: rtl/pea_scheduler.sv
// CFDF firing scheduler for the PEA actor: presents a mode, waits for the
// enable verdict, strobes invoke, waits for firing completion with a
// watchdog, follows the actor's requested next mode and pops one
// result/status pair after every OUTPUT firing.
module pea_scheduler #(
  parameter int FC_TIMEOUT = 1024,
  parameter int CNT_W      = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pea_scheduler_if.master sch
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FIRE, S_WAIT_FC, S_DRAIN, S_ERROR
  } state_t;

  localparam logic [1:0] M_SETUP  = 2'b00;
  localparam logic [1:0] M_OUTPUT = 2'b10;
  localparam logic [1:0] M_BAD    = 2'b11;

  // Counter is cleared in FIRE and first seen as 0 in WAIT_FC; leaving on
  // this value puts ERROR exactly FC_TIMEOUT cycles after the FIRE cycle.
  localparam logic [15:0] TO_LAST = 16'(FC_TIMEOUT - 2);

  state_t      r_state;
  logic [1:0]  r_next_mode;
  logic        r_invoke;
  logic        r_rd_en_result;
  logic        r_rd_en_status;
  logic        r_busy;
  logic        r_error;
  logic [15:0] r_firing_count;
  logic [15:0] r_cnt;
  logic        r_halt_pending;

  logic w_result_nz;
  logic w_status_nz;
  logic w_halt_ok;

  assign w_result_nz = (sch.result_count != {CNT_W{1'b0}});
  assign w_status_nz = (sch.status_count != {CNT_W{1'b0}});
  assign w_halt_ok   = sch.halt && (r_state inside {S_CHECK, S_FIRE, S_WAIT_FC, S_DRAIN});

  // Scheduler FSM; every output is a register updated alongside the state.
  // next_mode is frozen for the whole firing, so at fc time it is the mode
  // that was fired and decides whether a DRAIN follows.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_next_mode    <= M_SETUP;
      r_invoke       <= 1'b0;
      r_rd_en_result <= 1'b0;
      r_rd_en_status <= 1'b0;
      r_busy         <= 1'b0;
      r_error        <= 1'b0;
      r_firing_count <= '0;
      r_cnt          <= '0;
      r_halt_pending <= 1'b0;
    end else begin
      r_invoke       <= 1'b0;
      r_rd_en_result <= 1'b0;
      r_rd_en_status <= 1'b0;
      if (w_halt_ok) r_halt_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (sch.start) begin
            r_next_mode <= M_SETUP;
            r_busy      <= 1'b1;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_halt_pending) begin
            r_halt_pending <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end else if (sch.enable) begin
            r_invoke <= 1'b1;
            r_state  <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_FC;
        end
        S_WAIT_FC: begin
          if (sch.fc) begin
            r_firing_count <= r_firing_count + 16'd1;
            if (sch.actor_next_mode == M_BAD) begin
              r_halt_pending <= 1'b0;
              r_busy         <= 1'b0;
              r_error        <= 1'b1;
              r_state        <= S_ERROR;
            end else begin
              r_next_mode <= sch.actor_next_mode;
              if (r_next_mode == M_OUTPUT) begin
                // Pop only non-empty FIFOs; one pop each per OUTPUT firing
                r_rd_en_result <= w_result_nz;
                r_rd_en_status <= w_status_nz;
                r_state        <= S_DRAIN;
              end else begin
                r_state <= S_CHECK;
              end
            end
          end else if (r_cnt == TO_LAST) begin
            r_halt_pending <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b1;
            r_state        <= S_ERROR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          r_state <= S_CHECK;
        end
        S_ERROR: begin
          if (sch.start) begin
            r_next_mode <= M_SETUP;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_CHECK;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sch.next_mode    = r_next_mode;
  assign sch.invoke       = r_invoke;
  assign sch.rd_en_result = r_rd_en_result;
  assign sch.rd_en_status = r_rd_en_status;
  assign sch.busy         = r_busy;
  assign sch.error        = r_error;
  assign sch.firing_count = r_firing_count;

endmodule

// File: tb/tb_pea_scheduler.sv
// Self-checking bench for pea_scheduler: scoreboard of expected
// (next_mode, firing_count, error) per firing and expected pop pairs per
// OUTPUT firing, pushed when fc is driven and popped after the edge.
module tb_pea_scheduler;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pea_scheduler_if #(.CNT_W(CW)) sch ();

  pea_scheduler #(.FC_TIMEOUT(8), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .sch   (sch.master)
  );

  typedef struct packed {
    logic [1:0]  nm;
    logic [15:0] fcnt;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] dq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int inv_cnt  = 0;
  int both_cnt = 0;
  logic [15:0] exp_cnt;
  logic [1:0]  cur_mode;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (sch.invoke) inv_cnt <= inv_cnt + 1;
    if (sch.rd_en_result && sch.rd_en_status) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sch.start = 0; sch.halt = 0; sch.enable = 0; sch.fc = 0;
    sch.actor_next_mode = 0; sch.result_count = 0; sch.status_count = 0;
    tick(); tick();
    rst = 1'b0;
    exp_cnt  = 16'd0;
    cur_mode = 2'b00;
    sb.delete();
    dq.delete();
  endtask

  task automatic do_start();
    sch.start = 1'b1;
    tick();
    sch.start = 1'b0;
    cur_mode = 2'b00;
  endtask

  task automatic wait_invoke(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sch.invoke) begin ok = 1'b1; break; end
      tick();
    end
    n_chk++;
    if (!ok) $display("FAIL wait_invoke: invoke not seen within 40 cycles, required 1");
    else n_pass++;
  endtask

  // One firing: wait for invoke, fc after d cycles with given next mode and
  // FIFO populations, then check the scoreboard entries.
  task automatic fire_one(input logic [1:0] anm, input int d,
                          input logic [CW-1:0] rc, input logic [CW-1:0] sc);
    bit ok;
    exp_t e;
    logic [1:0] dexp;
    logic [1:0] fired;
    bit drain;
    wait_invoke(ok);
    if (!ok) return;
    fired = cur_mode;
    repeat (d) tick();
    sch.fc = 1'b1; sch.actor_next_mode = anm;
    sch.result_count = rc; sch.status_count = sc;
    exp_cnt = exp_cnt + 16'd1;
    e.fcnt = exp_cnt;
    e.err  = (anm == 2'b11);
    e.nm   = (anm == 2'b11) ? cur_mode : anm;
    sb.push_back(e);
    drain = (anm != 2'b11) && (fired == 2'b10);
    if (drain) dq.push_back({rc != 0, sc != 0});
    tick();
    sch.fc = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (sch.firing_count !== e.fcnt) $display("FAIL firing_count: got %0d exp %0d", sch.firing_count, e.fcnt);
    else n_pass++;
    n_chk++;
    if (sch.next_mode !== e.nm) $display("FAIL next_mode: got %b exp %b", sch.next_mode, e.nm);
    else n_pass++;
    n_chk++;
    if (sch.error !== e.err) $display("FAIL error_after_fc: got %b exp %b", sch.error, e.err);
    else n_pass++;
    if (anm != 2'b11) cur_mode = anm;
    if (drain) begin
      dexp = dq.pop_front();
      n_chk++;
      if ({sch.rd_en_result, sch.rd_en_status} !== dexp)
        $display("FAIL drain_pops: got %b%b exp %b", sch.rd_en_result, sch.rd_en_status, dexp);
      else n_pass++;
      tick();
      n_chk++;
      if ({sch.rd_en_result, sch.rd_en_status} !== 2'b00)
        $display("FAIL pop_width: got %b%b exp 00", sch.rd_en_result, sch.rd_en_status);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_chk++;
    if ({sch.next_mode, sch.invoke, sch.rd_en_result, sch.rd_en_status, sch.busy, sch.error} !== 7'd0)
      $display("FAIL reset_ctrl: got %b exp 0", {sch.next_mode, sch.invoke, sch.rd_en_result,
               sch.rd_en_status, sch.busy, sch.error});
    else n_pass++;
    n_chk++;
    if (sch.firing_count !== 16'd0) $display("FAIL reset_count: got %0d exp 0", sch.firing_count);
    else n_pass++;
  endtask

  task automatic test_full_cycle();
    int inv0;
    int both0;
    do_reset();
    sch.enable = 1'b1;
    do_start();
    inv0 = inv_cnt; both0 = both_cnt;
    n_chk++;
    if ({sch.busy, sch.next_mode} !== 3'b100) $display("FAIL start_check: got busy,mode=%b exp 100", {sch.busy, sch.next_mode});
    else n_pass++;
    fire_one(2'b01, 3, 5'd0, 5'd0);
    fire_one(2'b10, 3, 5'd0, 5'd0);
    fire_one(2'b00, 3, 5'd1, 5'd1);
    n_chk++;
    if (inv_cnt - inv0 !== 3) $display("FAIL invoke_pulses: got %0d exp 3", inv_cnt - inv0);
    else n_pass++;
    n_chk++;
    if (both_cnt - both0 !== 1) $display("FAIL both_pop_cycles: got %0d exp 1", both_cnt - both0);
    else n_pass++;
    sch.enable = 1'b0;
  endtask

  task automatic test_starvation();
    bit bad;
    do_reset();
    do_start();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!sch.busy || sch.invoke || sch.error) bad = 1'b1;
      tick();
    end
    n_chk++;
    if (bad) $display("FAIL starve_hold: got deviation from busy=1 invoke=0 error=0, required none");
    else n_pass++;
    sch.enable = 1'b1;
    tick();
    n_chk++;
    if (sch.invoke !== 1'b1) $display("FAIL starve_invoke: got %b exp 1", sch.invoke);
    else n_pass++;
    sch.enable = 1'b0;
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    sch.enable = 1'b1;
    do_start();
    fire_one(2'b01, 2, 5'd0, 5'd0);
    wait_invoke(ok);
    repeat (7) tick();
    n_chk++;
    if (sch.error !== 1'b0) $display("FAIL wd_early: got error=%b exp 0 at 7 cycles", sch.error);
    else n_pass++;
    tick();
    n_chk++;
    if ({sch.error, sch.busy, sch.invoke} !== 3'b100)
      $display("FAIL wd_error: got error,busy,invoke=%b exp 100", {sch.error, sch.busy, sch.invoke});
    else n_pass++;
    sch.enable = 1'b0;
    do_start();
    n_chk++;
    if ({sch.busy, sch.error, sch.next_mode} !== 4'b1000)
      $display("FAIL wd_restart: got busy,error,mode=%b exp 1000", {sch.busy, sch.error, sch.next_mode});
    else n_pass++;
    n_chk++;
    if (sch.firing_count !== exp_cnt) $display("FAIL wd_count: got %0d exp %0d", sch.firing_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_halt();
    bit ok;
    int inv0;
    do_reset();
    sch.enable = 1'b1;
    do_start();
    fire_one(2'b01, 2, 5'd0, 5'd0);
    wait_invoke(ok);
    tick();
    sch.halt = 1'b1;
    tick();
    sch.halt = 1'b0;
    repeat (4) tick();
    sch.fc = 1'b1; sch.actor_next_mode = 2'b01;
    tick();
    sch.fc = 1'b0;
    n_chk++;
    if ({sch.busy, sch.firing_count} !== {1'b1, 16'd2})
      $display("FAIL halt_completes: got busy=%b count=%0d exp busy=1 count=2", sch.busy, sch.firing_count);
    else n_pass++;
    tick();
    inv0 = inv_cnt;
    repeat (10) tick();
    n_chk++;
    if (sch.busy !== 1'b0) $display("FAIL halt_idle: got busy=%b exp 0", sch.busy);
    else n_pass++;
    n_chk++;
    if (inv_cnt - inv0 !== 0) $display("FAIL halt_no_invoke: got %0d invokes exp 0", inv_cnt - inv0);
    else n_pass++;
    sch.halt = 1'b1; sch.start = 1'b1;
    tick();
    sch.halt = 1'b0; sch.start = 1'b0;
    n_chk++;
    if ({sch.busy, sch.next_mode} !== 3'b100) $display("FAIL halt_start: got busy,mode=%b exp 100", {sch.busy, sch.next_mode});
    else n_pass++;
    wait_invoke(ok);
    sch.enable = 1'b0;
  endtask

  task automatic test_illegal_drain();
    do_reset();
    sch.enable = 1'b1;
    do_start();
    fire_one(2'b10, 1, 5'd0, 5'd0);
    fire_one(2'b00, 2, 5'd0, 5'd2);
    fire_one(2'b11, 1, 5'd0, 5'd0);
    n_chk++;
    if ({sch.busy, sch.invoke} !== 2'b00) $display("FAIL illegal_busy: got busy,invoke=%b exp 00", {sch.busy, sch.invoke});
    else n_pass++;
    sch.enable = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    sch.enable = 1'b1;
    do_start();
    fire_one(2'b10, 1, 5'd0, 5'd0);
    wait_invoke(ok);
    tick();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({sch.next_mode, sch.invoke, sch.rd_en_result, sch.rd_en_status, sch.busy, sch.error} !== 7'd0)
      $display("FAIL async_ctrl: got %b exp 0", {sch.next_mode, sch.invoke, sch.rd_en_result,
               sch.rd_en_status, sch.busy, sch.error});
    else n_pass++;
    n_chk++;
    if (sch.firing_count !== 16'd0) $display("FAIL async_count: got %0d exp 0", sch.firing_count);
    else n_pass++;
    sch.enable = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sch.start = 0; sch.halt = 0; sch.enable = 0; sch.fc = 0;
    sch.actor_next_mode = 0; sch.result_count = 0; sch.status_count = 0;
    test_reset();
    test_full_cycle();
    test_starvation();
    test_watchdog();
    test_halt();
    test_illegal_drain();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pea_scheduler.md
# pea_scheduler

Sequences firings of the polynomial evaluation accelerator (PEA) actor under CFDF semantics. It replaces the hand-written firing loop in the PEA benches with a hardware scheduler. It drives the actor's mode, checks the enable module's verdict and issues one-cycle invokes. It also waits for firing completion (FC), follows the actor's requested next mode, and drains one result/status word pair after every OUTPUT firing. It sits between the PEA enable module, the PEA invoke module and the result/status output FIFOs.

## Interface
- `FC_TIMEOUT`, default 1024: maximum cycles in WAIT_FC before error. Legal range is 2..65535.
- `CNT_W`, default 5: width of output-FIFO population inputs (log2 of 32-deep FIFOs).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins scheduling from SETUP_INSTR. Also clears ERROR.
- `halt`  in  1  pulse; stop scheduling at the next firing boundary.
- `enable`  in  1  from PEA enable module; enough tokens/space for `next_mode`.
- `fc`  in  1  firing-complete from PEA invoke module.
- `actor_next_mode`  in  2  actor's requested next mode, valid while `fc`=1.
- `result_count`  in  CNT_W  population of result output FIFO.
- `status_count`  in  CNT_W  population of status output FIFO.
- `next_mode`  out  2  mode presented to actor and enable module. Encoding: SETUP_INSTR=00, INSTR=01, OUTPUT=10.
- `invoke`  out  1  one-cycle firing strobe.
- `rd_en_result`  out  1  pop strobe to result FIFO.
- `rd_en_status`  out  1  pop strobe to status FIFO.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `error`  out  1  high in ERROR.
- `firing_count`  out  16  completed firings, wraps at 2^16.

## Operation
- States: IDLE, CHECK, FIRE, WAIT_FC, DRAIN, ERROR. All outputs are registered.
- **IDLE:** if `start` is high, set `next_mode`=00 and go to CHECK. Otherwise stay in IDLE.
- **CHECK:** if `halt_pending` is set, go to IDLE. Otherwise, if `enable` is high, go to FIRE. Otherwise stay in CHECK; starvation is not an error.
- **FIRE:** `invoke`=1 for exactly this cycle. Clear the timeout counter and go to WAIT_FC.
- **WAIT_FC:** `fc` is sampled only in this state.
  - On `fc`: increment `firing_count` and latch `mode_fired`=`next_mode`.
  - If `actor_next_mode`=11, go to ERROR.
  - Else if `mode_fired`=10, load `next_mode` from `actor_next_mode` and go to DRAIN.
  - Else load `next_mode` and go to CHECK.
  - Without `fc`: increment the counter. When the counter reaches FC_TIMEOUT-1, go to ERROR. If `fc` arrives in the same cycle, `fc` wins.
- **DRAIN:** lasts one cycle. `rd_en_result`=(`result_count`!=0) and `rd_en_status`=(`status_count`!=0). Then go to CHECK, which honours `halt_pending`.
- **ERROR:** `invoke`, `rd_en_*` and `busy` are all 0, and `error`=1. On `start`: `next_mode`=00, go to CHECK; `error` drops the same edge.
- **halt_pending:**
  - Set by `halt` in CHECK, FIRE, WAIT_FC or DRAIN.
  - Cleared on entry to IDLE or ERROR.
  - Ignored in IDLE and ERROR.
  - A halt never aborts a firing in progress.
- `start` while `busy` is ignored.
- `next_mode` changes only on leaving IDLE/ERROR via `start`, or on an accepted `fc`. It is stable for all of CHECK, FIRE and WAIT_FC.

## Timing
- Reset: state=IDLE, `next_mode`=00, `invoke`=0, `rd_en_result`=0, `rd_en_status`=0, `busy`=0, `error`=0, `firing_count`=0, `halt_pending`=0, timeout counter=0. Reset applies immediately, mid-firing included.
- `start` sampled at edge 0 → CHECK in cycle 1.
- With `enable`=1 in cycle 1, `invoke`=1 in cycle 2 and WAIT_FC from cycle 3.
- `fc` sampled at edge k → new `next_mode` and `firing_count` visible in cycle k+1, state CHECK (or DRAIN after an OUTPUT firing).
- Minimum firing period is 3 cycles (CHECK, FIRE, 1×WAIT_FC). An OUTPUT firing adds 1 cycle for DRAIN.
- Timeout: with no `fc`, ERROR is entered FC_TIMEOUT cycles after the FIRE cycle.
- Pop strobes are one cycle wide and occur only in DRAIN. There is at most one pop per FIFO per OUTPUT firing, so there is never an over-read on an empty FIFO.

## Test plan
- **Full cycle:** `start`; `enable` held 1; `fc` 3 cycles after each `invoke` with `actor_next_mode` 01, 10, 00; counts=1 at OUTPUT completion.
  - `next_mode` sequence 00→01→10→00.
  - Exactly three `invoke` pulses.
  - One cycle with both `rd_en` high.
  - `firing_count`=3.
- **Starvation:** `enable`=0 for 20 cycles after `start`, then 1.
  - State stays CHECK with no `invoke` and `error`=0.
  - `invoke` rises 1 cycle after `enable` is sampled high.
- **Watchdog:** FC_TIMEOUT=8, `fc` never asserted.
  - `error`=1 and `busy`=0 exactly 8 cycles after `invoke`.
  - A following `start` returns to CHECK with `next_mode`=00 and `error`=0.
- **Halt:** `halt` pulsed during WAIT_FC of an INSTR firing; `fc` 5 cycles later.
  - The firing completes and `firing_count` increments.
  - State goes to IDLE with no further `invoke`.
  - `start` in the same cycle as `halt` in IDLE yields CHECK.
- **Illegal mode / drain edge:** `fc` with `actor_next_mode`=11 → ERROR. OUTPUT completion with `result_count`=0, `status_count`=2 → only `rd_en_status` pulses.
- **Async reset:** assert `rst` mid-WAIT_FC → all outputs return to reset values immediately, before the next clock edge.
